// File: rtl/sd_buf_pkg.sv
// Shared word type and byte-order helper for the SD data block buffer.
package sd_buf_pkg;

  localparam int SD_BUF_WORD_W = 32;

  typedef logic [SD_BUF_WORD_W-1:0] sd_word_t;

  // Reverse byte order: {b3,b2,b1,b0} -> {b0,b1,b2,b3}.
  function automatic sd_word_t byte_swap(input sd_word_t w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sd_word_fifo.sv
// Single-clock word FIFO with level counter; read port is either
// first-word-fall-through (combinational head) or registered (head loaded
// on pop, holds otherwise, cleared by reset but not by flush).
module sd_word_fifo
  import sd_buf_pkg::*;
#(
  parameter int DEPTH_LOG2 = 7,
  parameter bit FWFT       = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  sd_word_t              i_wdata,
  input  logic                  i_pop,
  output sd_word_t              o_rdata,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  sd_word_t                r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   r_wptr;
  logic [DEPTH_LOG2-1:0]   r_rptr;
  logic [DEPTH_LOG2:0]     r_level;
  logic                    w_pop_ok;
  logic                    w_push_ok;

  assign o_level = r_level;
  assign o_full  = (r_level == FULL_LEVEL);
  assign o_empty = (r_level == '0);

  // A pop needs data; a push needs room, which a same-cycle pop provides
  // when full. On empty, a pop is refused so only the push lands.
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // Storage write; contents are never reset.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && !i_flush && w_push_ok) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointers and level; flush has priority over any same-cycle push/pop.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + DEPTH_LOG2'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + DEPTH_LOG2'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + (DEPTH_LOG2 + 1)'(1);
        2'b01:   r_level <= r_level - (DEPTH_LOG2 + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign o_rdata = r_mem[r_rptr];
    end else begin : g_reg
      sd_word_t r_rdata;
      // Registered head: loads on an accepted pop, holds otherwise.
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          r_rdata <= '0;
        end else if (!i_flush && w_pop_ok) begin
          r_rdata <= r_mem[r_rptr];
        end
      end
      assign o_rdata = r_rdata;
    end
  endgenerate

endmodule

// File: rtl/sd_data_block_buffer.sv
// Word buffer between the host data port and the SD serial engine.
// TX: host valid/ready push, engine pops on rd into registered data_in.
// RX: engine pushes on we_o, host pops through an FWFT valid/ready port.
// Handshake: a host transfer happens on a cycle where valid && ready are
// both high at the clock edge; ready/valid outputs depend only on levels.
// Optional macro SD_DATA_BYTE_SWAP_EN: byte-reverse words on both paths.
module sd_data_block_buffer
  import sd_buf_pkg::*;
#(
  parameter int DEPTH_LOG2 = 7
) (
  input  logic                  sd_clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [31:0]           tx_wdata,
  input  logic                  tx_wvalid,
  output logic                  tx_wready,
  input  logic                  rd,
  output logic [31:0]           data_in,
  input  logic [31:0]           data_out_o,
  input  logic                  we_o,
  output logic [31:0]           rx_rdata,
  output logic                  rx_rvalid,
  input  logic                  rx_rready,
  output logic [DEPTH_LOG2:0]   tx_level,
  output logic [DEPTH_LOG2:0]   rx_level,
  output logic                  tx_underrun,
  output logic                  rx_overrun
);

  sd_word_t w_tx_rdata;
  sd_word_t w_rx_wdata;
  logic     w_tx_full;
  logic     w_tx_empty;
  logic     w_rx_full;
  logic     w_rx_empty;
  logic     r_tx_underrun;
  logic     r_rx_overrun;

`ifdef SD_DATA_BYTE_SWAP_EN
  assign data_in    = byte_swap(w_tx_rdata);
  assign w_rx_wdata = byte_swap(data_out_o);
`else
  assign data_in    = w_tx_rdata;
  assign w_rx_wdata = data_out_o;
`endif

  assign tx_wready   = !w_tx_full;
  assign rx_rvalid   = !w_rx_empty;
  assign tx_underrun = r_tx_underrun;
  assign rx_overrun  = r_rx_overrun;

  sd_word_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .FWFT       (1'b0)
  ) u_tx_fifo (
    .i_clk   (sd_clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .i_push  (tx_wvalid && tx_wready),
    .i_wdata (tx_wdata),
    .i_pop   (rd),
    .o_rdata (w_tx_rdata),
    .o_level (tx_level),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  sd_word_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .FWFT       (1'b1)
  ) u_rx_fifo (
    .i_clk   (sd_clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .i_push  (we_o),
    .i_wdata (w_rx_wdata),
    .i_pop   (rx_rready),
    .o_rdata (rx_rdata),
    .o_level (rx_level),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  // Sticky error flags: set by a refused rd or a dropped RX word, cleared
  // only by flush or reset. A full RX with a same-cycle pop drops nothing.
  always_ff @(posedge sd_clk) begin
    if (!rst_n || flush) begin
      r_tx_underrun <= 1'b0;
      r_rx_overrun  <= 1'b0;
    end else begin
      if (rd && w_tx_empty)                  r_tx_underrun <= 1'b1;
      if (we_o && w_rx_full && !rx_rready)   r_rx_overrun  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sd_data_block_buffer.sv
// Self-checking bench for sd_data_block_buffer: queue-based reference model,
// per-cycle compare on the falling edge, directed scenarios with literal
// expectations, then randomized traffic.
module tb_sd_data_block_buffer;

  localparam int DL2   = 7;
  localparam int DEPTH = 128;

  logic           sd_clk;
  logic           rst_n;
  logic           flush;
  logic [31:0]    tx_wdata;
  logic           tx_wvalid;
  logic           tx_wready;
  logic           rd;
  logic [31:0]    data_in;
  logic [31:0]    data_out_o;
  logic           we_o;
  logic [31:0]    rx_rdata;
  logic           rx_rvalid;
  logic           rx_rready;
  logic [DL2:0]   tx_level;
  logic [DL2:0]   rx_level;
  logic           tx_underrun;
  logic           rx_overrun;

  sd_data_block_buffer #(.DEPTH_LOG2(DL2)) dut (
    .sd_clk      (sd_clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .tx_wdata    (tx_wdata),
    .tx_wvalid   (tx_wvalid),
    .tx_wready   (tx_wready),
    .rd          (rd),
    .data_in     (data_in),
    .data_out_o  (data_out_o),
    .we_o        (we_o),
    .rx_rdata    (rx_rdata),
    .rx_rvalid   (rx_rvalid),
    .rx_rready   (rx_rready),
    .tx_level    (tx_level),
    .rx_level    (rx_level),
    .tx_underrun (tx_underrun),
    .rx_overrun  (rx_overrun)
  );

  // ---------------- clock / reset ----------------
  initial begin
    sd_clk = 1'b0;
    forever #5 sd_clk = ~sd_clk;
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  logic [31:0] tx_q[$];
  logic [31:0] exp_q[$];   // expected RX words, head first
  logic [31:0] m_data_in   = '0;
  logic        m_underrun  = 1'b0;
  logic        m_overrun   = 1'b0;
  bit          m_tx_pop, m_tx_push, m_rx_pop, m_rx_push;

  // Host-order -> stored/presented order for the configured build.
  function automatic logic [31:0] sw(input logic [31:0] w);
    logic [31:0] r;
`ifdef SD_DATA_BYTE_SWAP_EN
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(3-i) +: 8];
`else
    r = w;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: two bounded queues plus a held output word and flags.
  always @(posedge sd_clk) begin
    if (!rst_n) begin
      tx_q.delete();
      exp_q.delete();
      m_data_in  = '0;
      m_underrun = 1'b0;
      m_overrun  = 1'b0;
    end else if (flush) begin
      tx_q.delete();
      exp_q.delete();
      m_underrun = 1'b0;
      m_overrun  = 1'b0;
    end else begin
      m_tx_pop  = rd && (tx_q.size() > 0);
      m_tx_push = tx_wvalid && (tx_q.size() < DEPTH);
      if (rd && tx_q.size() == 0) m_underrun = 1'b1;
      if (m_tx_pop) m_data_in = sw(tx_q.pop_front());
      if (m_tx_push) tx_q.push_back(tx_wdata);

      m_rx_pop  = rx_rready && (exp_q.size() > 0);
      m_rx_push = we_o && ((exp_q.size() < DEPTH) || m_rx_pop);
      if (we_o && !m_rx_push) m_overrun = 1'b1;
      if (m_rx_pop) void'(exp_q.pop_front());
      if (m_rx_push) exp_q.push_back(sw(data_out_o));
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge sd_clk) begin
    if (check_en) begin
      check("tx_level",    32'(tx_level),    32'(tx_q.size()));
      check("rx_level",    32'(rx_level),    32'(exp_q.size()));
      check("tx_wready",   32'(tx_wready),   32'(tx_q.size() != DEPTH));
      check("rx_rvalid",   32'(rx_rvalid),   32'(exp_q.size() != 0));
      check("tx_underrun", 32'(tx_underrun), 32'(m_underrun));
      check("rx_overrun",  32'(rx_overrun),  32'(m_overrun));
      check("data_in",     data_in,          m_data_in);
      if (exp_q.size() > 0) check("rx_rdata", rx_rdata, exp_q[0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge sd_clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush     = 1'b0;
    tx_wvalid = 1'b0;
    tx_wdata  = '0;
    rd        = 1'b0;
    we_o      = 1'b0;
    data_out_o = '0;
    rx_rready = 1'b0;
  endtask

  task automatic do_flush();
    idle_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic host_push(input logic [31:0] w);
    idle_inputs();
    tx_wvalid = 1'b1;
    tx_wdata  = w;
    tick();
    idle_inputs();
  endtask

  task automatic eng_rd();
    idle_inputs();
    rd = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic eng_we(input logic [31:0] w, input logic pop);
    idle_inputs();
    we_o       = 1'b1;
    data_out_o = w;
    rx_rready  = pop;
    tick();
    idle_inputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) tick();
    check_en = 1'b1;
    check("reset_data_in",   data_in,          32'h0);
    check("reset_tx_level",  32'(tx_level),    32'd0);
    check("reset_tx_wready", 32'(tx_wready),   32'd1);
    check("reset_rx_rvalid", 32'(rx_rvalid),   32'd0);
    rst_n = 1'b1;
    tick();

    // TX fill to 128, one extra offered word is refused.
    for (int i = 0; i < DEPTH; i++) host_push(32'(i));
    check("tx_full_level",  32'(tx_level),  32'd128);
    check("tx_full_wready", 32'(tx_wready), 32'd0);
    host_push(32'hDEAD_BEEF);
    check("tx_full_hold",   32'(tx_level),  32'd128);

    // 128 back-to-back rd pulses.
    idle_inputs();
    rd = 1'b1;
    tick();
    check("tx_first_word", data_in, sw(32'h0));
    for (int i = 1; i < DEPTH; i++) tick();
    idle_inputs();
    check("tx_last_word",   data_in,       sw(32'h7F));
    check("tx_drain_level", 32'(tx_level), 32'd0);

    // RX overfill with no host pops.
    for (int i = 0; i < 130; i++) begin
      eng_we(32'h100 + 32'(i), 1'b0);
      if (i == 127) check("rx_no_ovr_at_128", 32'(rx_overrun), 32'd0);
      if (i == 128) check("rx_ovr_at_129",    32'(rx_overrun), 32'd1);
    end
    check("rx_full_level", 32'(rx_level), 32'd128);
    check("rx_head_kept",  rx_rdata,      sw(32'h100));

    // rd on empty TX.
    eng_rd();
    check("underrun_hold", data_in,          sw(32'h7F));
    check("underrun_set",  32'(tx_underrun), 32'd1);
    do_flush();
    check("flush_underrun", 32'(tx_underrun), 32'd0);
    check("flush_overrun",  32'(rx_overrun),  32'd0);
    check("flush_tx_level", 32'(tx_level),    32'd0);
    check("flush_data_in",  data_in,          sw(32'h7F));

    // Simultaneous RX push/pop at level 5, then on empty.
    for (int i = 0; i < 5; i++) eng_we(32'h200 + 32'(i), 1'b0);
    eng_we(32'h205, 1'b1);
    check("rx_pp_level", 32'(rx_level), 32'd5);
    check("rx_pp_head",  rx_rdata,      sw(32'h201));
    do_flush();
    eng_we(32'h300, 1'b1);
    check("rx_pp_empty_level", 32'(rx_level), 32'd1);
    check("rx_pp_empty_head",  rx_rdata,      sw(32'h300));

    // Byte order.
    do_flush();
    host_push(32'h1122_3344);
    eng_rd();
    eng_we(32'hAABB_CCDD, 1'b0);
`ifdef SD_DATA_BYTE_SWAP_EN
    check("swap_tx", data_in,  32'h4433_2211);
    check("swap_rx", rx_rdata, 32'hDDCC_BBAA);
`else
    check("swap_tx", data_in,  32'h1122_3344);
    check("swap_rx", rx_rdata, 32'hAABB_CCDD);
`endif

    // Reset mid-transfer.
    do_flush();
    for (int i = 0; i < 40; i++) begin
      idle_inputs();
      tx_wvalid = 1'b1;
      tx_wdata  = 32'h500 + 32'(i);
      if (i < 7) begin
        we_o       = 1'b1;
        data_out_o = 32'h600 + 32'(i);
      end
      tick();
    end
    idle_inputs();
    eng_rd();
    check("mid_tx_level", 32'(tx_level), 32'd39);
    check("mid_rx_level", 32'(rx_level), 32'd7);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_tx_level", 32'(tx_level),    32'd0);
    check("rst_rx_level", 32'(rx_level),    32'd0);
    check("rst_flags",    32'({tx_underrun, rx_overrun}), 32'd0);
    check("rst_data_in",  data_in,          32'h0);

    // Randomized traffic: fill-biased phase, then drain-biased phase.
    for (int i = 0; i < 3000; i++) begin
      flush      = ($urandom_range(0, 499) == 0);
      tx_wvalid  = ($urandom_range(0, 3) != 0);
      tx_wdata   = $urandom;
      we_o       = ($urandom_range(0, 3) != 0);
      data_out_o = $urandom;
      if (i < 1500) begin
        rd        = ($urandom_range(0, 3) == 0);
        rx_rready = ($urandom_range(0, 3) == 0);
      end else begin
        rd        = ($urandom_range(0, 3) != 0);
        rx_rready = ($urandom_range(0, 7) != 0);
        tx_wvalid = ($urandom_range(0, 3) == 0);
        we_o      = ($urandom_range(0, 3) == 0);
      end
      tick();
    end
    idle_inputs();
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
